// File: rtl/rforest_pkg.sv
// Shared forest-voting types and defaults: FSM state encoding, default class
// geometry used by the tree engines, and the saturating counter step.
package rforest_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_N_CLASSES = 32;
    localparam int DEF_CLASS_W   = 5;
    localparam int DEF_MAX_VOTES = 255;

    function automatic int unsigned sat_inc(input int unsigned cnt, input int unsigned max_votes);
        return (cnt >= max_votes) ? cnt : cnt + 1;
    endfunction

endpackage

// File: rtl/rforest_class_counter.sv
// Per-class vote counter array: saturating increment by index, synchronous
// clear of the whole array, and a combinational indexed read port.
module rforest_class_counter
    import rforest_pkg::*;
#(
    parameter int N_CLASSES = DEF_N_CLASSES,
    parameter int CLASS_W   = DEF_CLASS_W,
    parameter int MAX_VOTES = DEF_MAX_VOTES,
    parameter int CNT_W     = $clog2(MAX_VOTES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc_en,
    input  logic [CLASS_W-1:0] inc_idx,
    input  logic               clr,
    input  logic [CLASS_W-1:0] rd_idx,
    output logic [CNT_W-1:0]   rd_cnt
);

    logic [CNT_W-1:0] cnt [N_CLASSES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CLASSES; i++) cnt[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < N_CLASSES; i++) cnt[i] <= '0;
        end else if (inc_en) begin
            for (int i = 0; i < N_CLASSES; i++) begin
                if (inc_idx == CLASS_W'(i))
                    cnt[i] <= CNT_W'(sat_inc(32'(cnt[i]), MAX_VOTES));
            end
        end
    end

    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < N_CLASSES; i++) begin
            if (rd_idx == CLASS_W'(i)) rd_cnt = cnt[i];
        end
    end

endmodule

// File: rtl/rforest_vote_accumulator.sv
// Streaming forest vote accumulator: counts per-class votes over a frame, then
// scans the counters one class per cycle and holds the argmax result for the sink.
module rforest_vote_accumulator
    import rforest_pkg::*;
#(
    parameter int N_CLASSES = DEF_N_CLASSES,
    parameter int CLASS_W   = DEF_CLASS_W,
    parameter int MAX_VOTES = DEF_MAX_VOTES,
    localparam int CNT_W    = $clog2(MAX_VOTES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vote_valid,
    output logic               vote_ready,
    input  logic [CLASS_W-1:0] vote_class,
    input  logic               vote_last,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CLASS_W-1:0] res_class,
    output logic [CNT_W-1:0]   res_count,
    output logic               res_tie,
    output logic               res_err,
    output logic               busy
);

    state_t             state, state_nxt;
    logic [CLASS_W-1:0] idx;
    logic [CLASS_W-1:0] best_cls;
    logic [CNT_W-1:0]   best_cnt;
    logic               tie;
    logic               err;
    logic [CNT_W-1:0]   rd_cnt;
    logic               accept;
    logic               in_range;
    logic               scan_done;
    logic               release_res;

    assign accept      = vote_valid && vote_ready;
    assign in_range    = {1'b0, vote_class} < (CLASS_W + 1)'(N_CLASSES);
    assign scan_done   = (idx == CLASS_W'(N_CLASSES - 1));
    assign release_res = (state == HOLD) && res_ready;

    rforest_class_counter #(
        .N_CLASSES (N_CLASSES),
        .CLASS_W   (CLASS_W),
        .MAX_VOTES (MAX_VOTES),
        .CNT_W     (CNT_W)
    ) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_en  (accept && in_range),
        .inc_idx (vote_class),
        .clr     (release_res),
        .rd_idx  (idx),
        .rd_cnt  (rd_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && vote_last) state_nxt = SCAN;
            SCAN:    if (scan_done)           state_nxt = HOLD;
            HOLD:    if (res_ready)           state_nxt = ACCUM;
            default:                          state_nxt = ACCUM;
        endcase
    end

    // Argmax scan: strict '>' keeps the lowest index on equal counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            best_cls <= '0;
            best_cnt <= '0;
            tie      <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (!in_range) err <= 1'b1;
                        if (vote_last) begin
                            idx      <= '0;
                            best_cls <= '0;
                            best_cnt <= '0;
                            tie      <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    if ((rd_cnt > best_cnt) || (idx == '0)) begin
                        best_cls <= idx;
                        best_cnt <= rd_cnt;
                        tie      <= 1'b0;
                    end else if (rd_cnt == best_cnt) begin
                        tie <= 1'b1;
                    end
                    idx <= idx + 1'b1;
                end
                HOLD: begin
                    if (res_ready) err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign vote_ready = (state == ACCUM);
    assign res_valid  = (state == HOLD);
    assign busy       = (state != ACCUM);
    assign res_class  = best_cls;
    assign res_count  = best_cnt;
    assign res_tie    = tie;
    assign res_err    = err;

endmodule

// File: tb/tb_rforest_vote_accumulator.sv
// Bench for rforest_vote_accumulator: directed frames with literal results plus
// randomized frames, all checked every cycle against a frame-level vote model.
module tb_rforest_vote_accumulator;

    localparam int N     = 20;
    localparam int CW    = 5;
    localparam int MV    = 255;
    localparam int CNT_W = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          vote_valid = 1'b0;
    logic          vote_ready;
    logic [CW-1:0] vote_class = '0;
    logic          vote_last = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [CW-1:0] res_class;
    logic [CNT_W-1:0] res_count;
    logic          res_tie;
    logic          res_err;
    logic          busy;

    always #5 clk = ~clk;

    rforest_vote_accumulator #(
        .N_CLASSES (N),
        .CLASS_W   (CW),
        .MAX_VOTES (MV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vote_valid (vote_valid),
        .vote_ready (vote_ready),
        .vote_class (vote_class),
        .vote_last  (vote_last),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_class  (res_class),
        .res_count  (res_count),
        .res_tie    (res_tie),
        .res_err    (res_err),
        .busy       (busy)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int rr_mode = 0;   // 0: sink always ready, 1: random, 2: driven by the test

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int cls;
        int cnt;
        int tie;
        int err;
        int acc_edge;
    } res_t;

    res_t exp_q[$];
    int   frame[$];

    // Frame-level reference: histogram with clamp, first maximum wins, tie if
    // the maximum is shared, err if any vote named a class outside 0..N-1.
    function automatic res_t model(input int votes[$], input int acc);
        res_t r;
        int counts[N];
        int best, nbest;
        for (int c = 0; c < N; c++) counts[c] = 0;
        r.err = 0;
        foreach (votes[k]) begin
            if (votes[k] < N) counts[votes[k]]++;
            else r.err = 1;
        end
        best = 0;
        for (int c = 0; c < N; c++) begin
            if (counts[c] > MV) counts[c] = MV;
            if (counts[c] > counts[best]) best = c;
        end
        nbest = 0;
        for (int c = 0; c < N; c++) if (counts[c] == counts[best]) nbest++;
        r.cls = best;
        r.cnt = counts[best];
        r.tie = (nbest > 1) ? 1 : 0;
        r.acc_edge = acc;
        return r;
    endfunction

    // Sampled on the falling edge: inputs seen here are what the next rising edge takes.
    logic prev_rv = 1'b0;
    res_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            frame.delete();
            prev_rv = 1'b0;
        end else begin
            check("ready_vs_busy", int'(vote_ready), int'(!busy));
            if (vote_valid && vote_ready) begin
                frame.push_back(int'(vote_class));
                if (vote_last) begin
                    exp_q.push_back(model(frame, cyc + 1));
                    frame.delete();
                end
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q[0];
                    check("res_class", int'(res_class), e.cls);
                    check("res_count", int'(res_count), e.cnt);
                    check("res_tie", int'(res_tie), e.tie);
                    check("res_err", int'(res_err), e.err);
                    check("hold_vote_ready", int'(vote_ready), 0);
                    if (!prev_rv) check("latency", cyc - e.acc_edge, N);
                    if (res_ready) void'(exp_q.pop_front());
                end
            end
            prev_rv = res_valid;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rr_mode == 0)      res_ready = 1'b1;
        else if (rr_mode == 1) res_ready = ($urandom_range(0, 2) != 0);
    end

    task automatic send_vote(input int cls, input bit last);
        vote_class = CW'(cls);
        vote_last  = last;
        vote_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (vote_ready) begin
                @(posedge clk);
                #1;
                vote_valid = 1'b0;
                vote_last  = 1'b0;
                return;
            end
        end
        check("send_timeout", 0, 1);
        vote_valid = 1'b0;
        vote_last  = 1'b0;
    endtask

    task automatic expect_res(input string name, input int c, input int n, input int t, input int er);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (res_valid) begin
                check({name, "_class"}, int'(res_class), c);
                check({name, "_count"}, int'(res_count), n);
                check({name, "_tie"}, int'(res_tie), t);
                check({name, "_err"}, int'(res_err), er);
                return;
            end
        end
        check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_vote_ready", int'(vote_ready), 1);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_res_class", int'(res_class), 0);
        check("rst_res_count", int'(res_count), 0);
        check("rst_res_tie", int'(res_tie), 0);
        check("rst_res_err", int'(res_err), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send_vote(3, 0); send_vote(3, 0); send_vote(7, 0); send_vote(3, 1);
        expect_res("f1", 3, 3, 0, 0);

        send_vote(9, 0); send_vote(4, 0); send_vote(9, 0); send_vote(4, 1);
        expect_res("f2", 4, 2, 1, 0);

        send_vote(5, 0); send_vote(31, 1);
        expect_res("f3", 5, 1, 0, 1);

        send_vote(31, 1);
        expect_res("f4", 0, 0, 1, 1);

        for (int k = 0; k < 300; k++) send_vote(2, k == 299);
        expect_res("sat", 2, 255, 0, 0);

        // Back-pressure: result must stay put and no vote may slip in.
        @(posedge clk);
        #1;
        rr_mode   = 2;
        res_ready = 1'b0;
        send_vote(6, 1);
        expect_res("hold", 6, 1, 0, 0);
        vote_class = CW'(8);
        vote_last  = 1'b1;
        vote_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_ready_low", int'(vote_ready), 0);
            check("hold_valid_high", int'(res_valid), 1);
            check("hold_class_stable", int'(res_class), 6);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_res_valid", int'(res_valid), 0);
        check("release_vote_ready", int'(vote_ready), 1);
        check("release_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        vote_valid = 1'b0;
        vote_last  = 1'b0;
        rr_mode    = 0;
        expect_res("after_hold", 8, 1, 0, 0);

        // Abort a frame mid-scan.
        send_vote(1, 0); send_vote(1, 0); send_vote(1, 1);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_res_valid", int'(res_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_res_count", int'(res_count), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        send_vote(1, 1);
        expect_res("post_abort", 1, 1, 0, 0);

        rr_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send_vote($urandom_range(0, 23), k == len - 1);
            end
        end

        rr_mode = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check("drain_pending", exp_q.size(), 0);
        check("drain_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
